// File: rtl/sprite_list_dma.sv
// sprite_list_dma: copies the CPU sprite list from work RAM into sprite RAM,
// compacting enabled records to the front and padding the tail with off-screen records.
// Latency: 10 cycles per enabled record and 6 per disabled one, plus 4 cycles per pad record.
// Backpressure: only work-RAM reads stall (src_grant); sprite-RAM writes are never stalled.
module sprite_list_dma #(
  parameter int          N_SPR    = 256,
  parameter logic [11:0] SRC_BASE = 12'h000
) (
  input  logic        master_clk,
  input  logic        reset,
  input  logic        start,
  input  logic        src_grant,
  output logic        src_rd,
  output logic [11:0] src_addr,
  input  logic [7:0]  src_din,
  output logic        spr_wr,
  output logic [10:0] spr_addr,
  output logic [7:0]  spr_dout,
  output logic        busy,
  output logic        done,
  output logic [8:0]  spr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CHECK,
    S_WRITE,
    S_FILL,
    S_DONE
  } state_t;

  // Record and byte limits, widened so N_SPR itself is representable.
  localparam logic [9:0]  LAST_REC  = 10'(N_SPR - 1);
  localparam logic [9:0]  N_REC     = 10'(N_SPR);
  localparam logic [10:0] LAST_BYTE = 11'(N_SPR * 4 - 1);

  state_t          state_q;
  logic [9:0]      rec_q;        // source record index
  logic [2:0]      rd_idx_q;     // next byte to read in this record; 4 = all reads issued
  logic            cap_vld_q;    // a read was issued last cycle, its data is on src_din now
  logic [1:0]      cap_idx_q;    // staging slot for that data
  logic [3:0][7:0] stage_q;      // staged record bytes 0..3
  logic [1:0]      wb_q;         // byte being written during WRITE

  logic [11:0]     src_addr_q;
  logic            spr_wr_q;
  logic [10:0]     spr_addr_q;
  logic [7:0]      spr_dout_q;
  logic            busy_q;
  logic            done_q;
  logic [8:0]      spr_count_q;

  logic            rd_issue;
  logic [9:0]      count_inc_d;

  // Pad record bytes {00, 00, F0, 00}: VPOS F0 sits below the visible area.
  function automatic logic [7:0] pad_byte(input logic [1:0] b);
    return (b == 2'd2) ? 8'hF0 : 8'h00;
  endfunction

  // The read strobe must follow the arbiter's same-cycle permission, so it is
  // gated combinationally; the address itself is registered and holds while stalled.
  assign rd_issue    = (state_q == S_READ) && !rd_idx_q[2] && src_grant;
  assign count_inc_d = {1'b0, spr_count_q} + 10'd1;

  assign src_rd    = rd_issue;
  assign src_addr  = src_addr_q;
  assign spr_wr    = spr_wr_q;
  assign spr_addr  = spr_addr_q;
  assign spr_dout  = spr_dout_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign spr_count = spr_count_q;

  // Copy sequencer: all state and registered outputs advance together here.
  always_ff @(posedge master_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rec_q       <= '0;
      rd_idx_q    <= '0;
      cap_vld_q   <= 1'b0;
      cap_idx_q   <= '0;
      stage_q     <= '0;
      wb_q        <= '0;
      src_addr_q  <= '0;
      spr_wr_q    <= 1'b0;
      spr_addr_q  <= '0;
      spr_dout_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      spr_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_READ;
            rec_q       <= '0;
            spr_count_q <= '0;
            busy_q      <= 1'b1;
            rd_idx_q    <= '0;
            cap_vld_q   <= 1'b0;
            src_addr_q  <= SRC_BASE;
          end
        end

        S_READ: begin
          // The address simply walks forward; after byte 3 it already points
          // at the next record, whether or not this one is kept.
          if (rd_issue) begin
            src_addr_q <= src_addr_q + 12'd1;
            rd_idx_q   <= rd_idx_q + 3'd1;
          end
          cap_vld_q <= rd_issue;
          cap_idx_q <= rd_idx_q[1:0];
          if (cap_vld_q) begin
            stage_q[cap_idx_q] <= src_din;
            if (cap_idx_q == 2'd3) begin
              state_q <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          if (stage_q[1][5]) begin
            // Disabled record: nothing written, move on.
            rec_q <= rec_q + 10'd1;
            if (rec_q == LAST_REC) begin
              if ({1'b0, spr_count_q} == N_REC) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q    <= S_FILL;
                spr_wr_q   <= 1'b1;
                spr_addr_q <= {spr_count_q, 2'b00};
                spr_dout_q <= pad_byte(2'd0);
              end
            end else begin
              state_q  <= S_READ;
              rd_idx_q <= '0;
            end
          end else begin
            // Present byte 0 of the record in the first WRITE cycle.
            state_q    <= S_WRITE;
            wb_q       <= '0;
            spr_wr_q   <= 1'b1;
            spr_addr_q <= {spr_count_q, 2'b00};
            spr_dout_q <= stage_q[0];
          end
        end

        S_WRITE: begin
          if (wb_q == 2'd3) begin
            spr_count_q <= spr_count_q + 9'd1;
            rec_q       <= rec_q + 10'd1;
            if (rec_q == LAST_REC) begin
              if (count_inc_d == N_REC) begin
                state_q  <= S_DONE;
                done_q   <= 1'b1;
                busy_q   <= 1'b0;
                spr_wr_q <= 1'b0;
              end else begin
                // Fill starts right after the last record byte, no gap cycle.
                state_q    <= S_FILL;
                spr_addr_q <= spr_addr_q + 11'd1;
                spr_dout_q <= pad_byte(2'd0);
              end
            end else begin
              state_q  <= S_READ;
              rd_idx_q <= '0;
              spr_wr_q <= 1'b0;
            end
          end else begin
            wb_q       <= wb_q + 2'd1;
            spr_addr_q <= spr_addr_q + 11'd1;
            spr_dout_q <= stage_q[wb_q + 2'd1];
          end
        end

        S_FILL: begin
          if (spr_addr_q == LAST_BYTE) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            spr_wr_q <= 1'b0;
          end else begin
            spr_addr_q <= spr_addr_q + 11'd1;
            spr_dout_q <= pad_byte(spr_addr_q[1:0] + 2'd1);
          end
        end

        S_DONE: begin
          // start is deliberately not looked at here.
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
